// File: rtl/branch_flush_ctrl.sv
// -----------------------------------------------------------------------------
// branch_flush_ctrl
//
// Purpose:
//   Sequences the PC redirect and pipeline flush that follow a taken branch
//   resolved in EXE. It also arbitrates between the branch redirect, a
//   load-use hazard stall and a memory-wait freeze.
//   Priority order: mem_Busy > branch > hazard.
//
// Optional feature:
//   Define BRANCH_STATS_EN to add two saturating statistics counters
//   (branch_Count, flush_Count) of width CNT_W. With the macro undefined,
//   the ports, the counters and the CNT_W parameter are all absent.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   synchronous reset, active-high
//   Branch_Taken    in   taken-branch indication from EXE
//   Br_Addr         in   branch target from EXE
//   hazard_Detected in   load-use hazard from ID
//   mem_Busy        in   memory stage multi-cycle wait
//   freeze_IF       out  hold PC
//   freeze_ID       out  hold IF/ID register
//   freeze_EXE      out  hold ID/EXE and later registers
//   ctrl_Bubble     out  zero ID control into ID/EXE
//   flush_IF_ID     out  clear IF/ID register
//   flush_ID_EXE    out  clear ID/EXE register
//   PC_Src_Sel      out  1 = load PC from PC_Target
//   PC_Target       out  registered branch target
//   branch_Count    out  accepted branches, saturating (BRANCH_STATS_EN only)
//   flush_Count     out  advancing flush cycles, saturating (BRANCH_STATS_EN only)
// -----------------------------------------------------------------------------
module branch_flush_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2   // legal range 1..15
`ifdef BRANCH_STATS_EN
  ,parameter int CNT_W       = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Branch_Taken,
  input  logic [ADDR_W-1:0] Br_Addr,
  input  logic              hazard_Detected,
  input  logic              mem_Busy,
  output logic              freeze_IF,
  output logic              freeze_ID,
  output logic              freeze_EXE,
  output logic              ctrl_Bubble,
  output logic              flush_IF_ID,
  output logic              flush_ID_EXE,
  output logic              PC_Src_Sel,
  output logic [ADDR_W-1:0] PC_Target
`ifdef BRANCH_STATS_EN
  ,output logic [CNT_W-1:0] branch_Count,
  output logic [CNT_W-1:0]  flush_Count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  // Remaining flush cycles after the REDIRECT cycle.
  localparam logic [3:0] FCNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          fcnt_q, fcnt_d;
  logic [ADDR_W-1:0]   pc_target_q, pc_target_d;
  logic                accept;     // RUN -> REDIRECT this cycle
  logic                advance;    // pipeline is allowed to move
  logic                hz;

  assign advance = ~mem_Busy;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    pc_target_d = pc_target_q;
    accept      = 1'b0;
    if (advance) begin
      unique case (state_q)
        RUN: begin
          if (Branch_Taken) begin
            accept      = 1'b1;
            pc_target_d = Br_Addr;
            fcnt_d      = FCNT_INIT;
            state_d     = REDIRECT;
          end
        end
        REDIRECT: state_d = (fcnt_q != 4'd0) ? FLUSH : RUN;
        FLUSH: begin
          fcnt_d = fcnt_q - 4'd1;
          // fcnt_q == 1 marks the final FLUSH cycle.
          if (fcnt_q == 4'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      fcnt_q      <= 4'd0;
      pc_target_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      pc_target_q <= pc_target_d;
    end
  end

  // Branch and hazard from flushed slots are ignored; a branch in the same
  // cycle as a hazard wins, so no stall is raised for it.
  assign hz = hazard_Detected & (state_q == RUN) & ~Branch_Taken;

  // Combinational outputs are forced low during reset; flush and redirect
  // are masked while memory is busy and reappear unchanged afterwards.
  assign freeze_EXE   = ~rst & mem_Busy;
  assign freeze_IF    = ~rst & (mem_Busy | hz);
  assign freeze_ID    = ~rst & (mem_Busy | hz);
  assign ctrl_Bubble  = ~rst & hz & ~mem_Busy;
  assign flush_IF_ID  = ~rst & advance & (state_q != RUN);
  assign flush_ID_EXE = ~rst & advance & (state_q != RUN);
  assign PC_Src_Sel   = ~rst & advance & (state_q == REDIRECT);
  assign PC_Target    = rst ? '0 : pc_target_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             flush_adv;

  assign flush_adv = advance & (state_q != RUN);

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (accept && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + 1'b1;
    if (flush_adv && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign branch_Count = rst ? '0 : branch_cnt_q;
  assign flush_Count  = rst ? '0 : flush_cnt_q;
`endif

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_flush_ctrl
//
// Self-checking bench for branch_flush_ctrl. A behavioural model tracks the
// number of flush cycles still owed and whether the redirect is still pending;
// every output is compared with it once per cycle, plus literal checks on the
// directed steps. Statistics counters are checked only when BRANCH_STATS_EN
// is defined (including a CNT_W=2 instance for saturation).
// -----------------------------------------------------------------------------
module tb_branch_flush_ctrl;

  localparam int ADDR_W = 32;
  localparam int FC     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              Branch_Taken;
  logic [ADDR_W-1:0] Br_Addr;
  logic              hazard_Detected;
  logic              mem_Busy;
  logic              freeze_IF, freeze_ID, freeze_EXE, ctrl_Bubble;
  logic              flush_IF_ID, flush_ID_EXE, PC_Src_Sel;
  logic [ADDR_W-1:0] PC_Target;

  always #5 clk = ~clk;

`ifdef BRANCH_STATS_EN
  logic [15:0]       branch_Count, flush_Count;
  logic [1:0]        s_branch_Count, s_flush_Count;
  logic              s_fif, s_fid, s_fex, s_bub, s_fl1, s_fl2, s_pcs;
  logic [ADDR_W-1:0] s_tgt;
`endif

  branch_flush_ctrl #(
    .ADDR_W(ADDR_W), .FLUSH_CYCLES(FC)
`ifdef BRANCH_STATS_EN
    , .CNT_W(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .Branch_Taken(Branch_Taken), .Br_Addr(Br_Addr),
    .hazard_Detected(hazard_Detected), .mem_Busy(mem_Busy),
    .freeze_IF(freeze_IF), .freeze_ID(freeze_ID), .freeze_EXE(freeze_EXE),
    .ctrl_Bubble(ctrl_Bubble), .flush_IF_ID(flush_IF_ID),
    .flush_ID_EXE(flush_ID_EXE), .PC_Src_Sel(PC_Src_Sel), .PC_Target(PC_Target)
`ifdef BRANCH_STATS_EN
    , .branch_Count(branch_Count), .flush_Count(flush_Count)
`endif
  );

`ifdef BRANCH_STATS_EN
  branch_flush_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(FC), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .Branch_Taken(Branch_Taken), .Br_Addr(Br_Addr),
    .hazard_Detected(hazard_Detected), .mem_Busy(mem_Busy),
    .freeze_IF(s_fif), .freeze_ID(s_fid), .freeze_EXE(s_fex),
    .ctrl_Bubble(s_bub), .flush_IF_ID(s_fl1), .flush_ID_EXE(s_fl2),
    .PC_Src_Sel(s_pcs), .PC_Target(s_tgt),
    .branch_Count(s_branch_Count), .flush_Count(s_flush_Count)
  );
`endif

  // ---------------- reference model ----------------
  int          m_owed;        // advancing flush cycles still to assert
  bit          m_redirect;    // first of those cycles not yet delivered
  logic [31:0] m_target;
  longint      m_branches;    // unsaturated totals
  longint      m_flushes;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? 32'(mx) : 32'(v);
  endfunction

  task automatic model_check();
    bit idle, hz, busy;
    idle = (m_owed == 0);
    busy = (mem_Busy === 1'b1);
    hz   = hazard_Detected && idle && !Branch_Taken;
    if (rst) begin
      check("rst_freeze_IF", freeze_IF, 0);
      check("rst_freeze_ID", freeze_ID, 0);
      check("rst_freeze_EXE", freeze_EXE, 0);
      check("rst_bubble", ctrl_Bubble, 0);
      check("rst_flush_IF_ID", flush_IF_ID, 0);
      check("rst_flush_ID_EXE", flush_ID_EXE, 0);
      check("rst_pc_src", PC_Src_Sel, 0);
      check("rst_pc_target", PC_Target, 0);
    end else begin
      check("freeze_IF", freeze_IF, 32'(busy || hz));
      check("freeze_ID", freeze_ID, 32'(busy || hz));
      check("freeze_EXE", freeze_EXE, 32'(busy));
      check("bubble", ctrl_Bubble, 32'(hz && !busy));
      check("flush_IF_ID", flush_IF_ID, 32'(!idle && !busy));
      check("flush_ID_EXE", flush_ID_EXE, 32'(!idle && !busy));
      check("pc_src", PC_Src_Sel, 32'(m_redirect && !busy));
      check("pc_target", PC_Target, m_target);
    end
`ifdef BRANCH_STATS_EN
    check("branch_count", 32'(branch_Count), rst ? 0 : sat(m_branches, 16));
    check("flush_count", 32'(flush_Count), rst ? 0 : sat(m_flushes, 16));
    check("branch_count_w2", 32'(s_branch_Count), rst ? 0 : sat(m_branches, 2));
    check("flush_count_w2", 32'(s_flush_Count), rst ? 0 : sat(m_flushes, 2));
`endif
  endtask

  // Applied right after the rising edge with the inputs the DUT just sampled.
  task automatic model_update();
    if (rst) begin
      m_owed = 0; m_redirect = 0; m_target = 0; m_branches = 0; m_flushes = 0;
    end else if (!mem_Busy) begin
      if (m_owed > 0) begin
        m_owed--;
        m_redirect = 0;
        m_flushes++;
      end else if (Branch_Taken) begin
        m_owed     = FC;
        m_redirect = 1;
        m_target   = Br_Addr;
        m_branches++;
      end
    end
  endtask

  task automatic drive(input logic r, input logic bt, input logic [31:0] ba,
                       input logic hz, input logic mb);
    rst = r; Branch_Taken = bt; Br_Addr = ba; hazard_Detected = hz; mem_Busy = mb;
    #1;
  endtask

  task automatic tick();
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    m_owed = 0; m_redirect = 0; m_target = 0; m_branches = 0; m_flushes = 0;
    @(negedge clk);

    // 1. reset with all inputs active
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 32'hDEAD_BEEF, 1, 1);
      check("t1_pc_target", PC_Target, 0);
      check("t1_freeze_EXE", freeze_EXE, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    check("t1_post_flush", flush_IF_ID, 0);
    tick();
    drive(0, 0, 0, 0, 0); tick();

    // 2. branch to 0x40
    drive(0, 1, 32'h40, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    check("t2_c1_pc_src", PC_Src_Sel, 1);
    check("t2_c1_target", PC_Target, 32'h40);
    check("t2_c1_flush", flush_ID_EXE, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    check("t2_c2_flush", flush_IF_ID, 1);
    check("t2_c2_pc_src", PC_Src_Sel, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("t2_c3_flush", flush_IF_ID, 0);
    tick();

    // 3. single hazard cycle
    drive(0, 0, 0, 1, 0);
    check("t3_bubble", ctrl_Bubble, 1);
    check("t3_freeze_IF", freeze_IF, 1);
    check("t3_freeze_EXE", freeze_EXE, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("t3_after", freeze_ID, 0);
    tick();

    // 4. branch and hazard together
    drive(0, 1, 32'h100, 1, 0);
    check("t4_no_freeze", freeze_IF, 0);
    check("t4_no_bubble", ctrl_Bubble, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("t4_pc_src", PC_Src_Sel, 1);
    check("t4_target", PC_Target, 32'h100);

    // 5. mem_Busy for 3 cycles starting in the REDIRECT cycle
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1);
      check("t5_pc_src_masked", PC_Src_Sel, 0);
      check("t5_flush_masked", flush_IF_ID, 0);
      check("t5_freeze", freeze_ID, 1);
      check("t5_target_held", PC_Target, 32'h100);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    check("t5_redirect_resumes", PC_Src_Sel, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    check("t5_flush_phase", flush_IF_ID, 1);
    check("t5_flush_no_pc", PC_Src_Sel, 0);
    tick();
    drive(0, 0, 0, 0, 0); tick();

    // 6. back-to-back branches (stats saturate on the narrow instance)
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 32'h200 + 32'(i * 4), 0, 0); tick();
      for (int j = 0; j < FC; j++) begin
        drive(0, 1, 32'hFFFF_0000, 1, 0); tick();  // ignored during flush
      end
    end
    drive(0, 0, 0, 0, 0); tick();

    // reset mid-flush
    drive(0, 1, 32'h300, 0, 0); tick();
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    check("rst_mid_no_flush", flush_IF_ID, 0);
    tick();

    // random phase
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0), $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
